cnn_layer_sched: RTL and testbench

Layer scheduler for the CNN accelerator subsystem. The CPU programs which layer engines to run, then issues one start command. The block starts each enabled layer wrapper in ascending index order, waits for that layer's completion interrupt, and acknowledges it. When all enabled layers are finished, it raises a single interrupt to the CPU. It sits between the CPU-side register port and the per-layer CNN wrappers.

---
 rtl/cnn_sched_pkg.sv | 32 +++
 rtl/cnn_sched_next_sel.sv | 32 +++
 rtl/cnn_layer_sched.sv | 197 +++++++++++++++++++
 tb/tb_cnn_layer_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_sched_pkg.sv
// Shared definitions for the CNN layer scheduler: FSM state encodings,
// register offsets and CTRL/STATUS bit positions.
package cnn_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LAUNCH = 3'd1;
  localparam state_t ST_WAIT   = 3'd2;
  localparam state_t ST_ACK    = 3'd3;
  localparam state_t ST_DONE   = 3'd4;
  localparam state_t ST_ERR    = 3'd5;

  localparam logic [3:0] REG_CTRL    = 4'h0;
  localparam logic [3:0] REG_MASK    = 4'h4;
  localparam logic [3:0] REG_STATUS  = 4'h8;
  localparam logic [3:0] REG_TIMEOUT = 4'hC;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_CLR = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERROR   = 2;
  localparam int STAT_CUR_LSB = 8;

  function automatic logic is_busy(input state_t st);
    return (st == ST_LAUNCH) || (st == ST_WAIT) || (st == ST_ACK);
  endfunction

endpackage

// File: rtl/cnn_sched_next_sel.sv
// Combinational priority encoder: lowest set bit of i_mask above i_idx
// (or at/above i_idx when i_incl is set), with a valid flag.
module cnn_sched_next_sel #(
  parameter int NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0] i_mask,
  input  logic [2:0]            i_idx,
  input  logic                  i_incl,
  output logic [2:0]            o_idx,
  output logic                  o_valid
);

  logic [NUM_LAYERS-1:0] w_cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_cand
      assign w_cand[gi] = i_mask[gi] &&
                          ((3'(gi) > i_idx) || (i_incl && (3'(gi) == i_idx)));
    end
  endgenerate

  // Scan from the top down so the lowest candidate is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = |w_cand;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (w_cand[i]) o_idx = 3'(i);
    end
  end

endmodule

// File: rtl/cnn_layer_sched.sv
// Layer scheduler: starts each enabled layer in ascending order, acks its done, IRQs at end.
// Optional macro CNN_SCHED_TIMEOUT_EN adds a per-layer WAIT timeout that ends in ERR.
module cnn_layer_sched
  import cnn_sched_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_wvalid,
  input  logic [3:0]            cfg_waddr,
  input  logic [31:0]           cfg_wdata,
  output logic                  cfg_wready,
  input  logic [3:0]            cfg_raddr,
  output logic [31:0]           cfg_rdata,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_ack,
  output logic                  sched_irq
);

  state_t                r_state;
  state_t                w_state_next;
  logic [NUM_LAYERS-1:0] r_mask;
  logic [NUM_LAYERS-1:0] r_mask_q;
  logic [NUM_LAYERS-1:0] w_mask_q_next;
  logic [2:0]            r_cur;
  logic [2:0]            w_cur_next;
  logic                  r_done;
  logic                  r_error;
  logic                  r_irq;

  logic                  w_wr_ctrl;
  logic                  w_wr_mask;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_irq_clr;
  logic                  w_busy;
  logic                  w_clr_flags;
  logic [NUM_LAYERS-1:0] w_cur_oh;
  logic                  w_done_cur;
  logic                  w_timeout_hit;
  logic [31:0]           w_timeout_rd;
  logic [NUM_LAYERS-1:0] w_sel_mask;
  logic [2:0]            w_sel_base;
  logic [2:0]            w_sel_idx;
  logic                  w_sel_valid;
  logic                  w_unused;

  assign w_wr_ctrl = cfg_wvalid && (cfg_waddr == REG_CTRL);
  assign w_wr_mask = cfg_wvalid && (cfg_waddr == REG_MASK);
  assign w_start   = w_wr_ctrl && cfg_wdata[CTRL_START];
  assign w_abort   = w_wr_ctrl && cfg_wdata[CTRL_ABORT];
  assign w_irq_clr = w_wr_ctrl && cfg_wdata[CTRL_IRQ_CLR];
  assign w_busy    = is_busy(r_state);
  assign w_unused  = ^cfg_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_cur_oh
      assign w_cur_oh[gi] = (r_cur == 3'(gi));
    end
  endgenerate

  // Only the bit of the layer currently being waited on matters.
  assign w_done_cur = |(layer_done & w_cur_oh);

  // In IDLE the search covers the live MASK from bit 0; afterwards it walks mask_q above cur.
  assign w_sel_mask = (r_state == ST_IDLE) ? r_mask : r_mask_q;
  assign w_sel_base = (r_state == ST_IDLE) ? 3'd0 : r_cur;

  cnn_sched_next_sel #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_next_sel (
    .i_mask  (w_sel_mask),
    .i_idx   (w_sel_base),
    .i_incl  (r_state == ST_IDLE),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_valid)
  );

`ifdef CNN_SCHED_TIMEOUT_EN
  logic [31:0] r_timeout;
  logic [31:0] r_wait_cnt;
  logic [31:0] w_wait_cnt_inc;

  // The incremented value counts the current WAIT cycle, so TIMEOUT=N allows exactly N cycles.
  assign w_wait_cnt_inc = r_wait_cnt + 32'd1;
  assign w_timeout_hit  = (r_state == ST_WAIT) && (r_timeout != '0) &&
                          (w_wait_cnt_inc == r_timeout);
  assign w_timeout_rd   = r_timeout;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_timeout  <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (cfg_wvalid && (cfg_waddr == REG_TIMEOUT)) r_timeout <= cfg_wdata;
      if (r_state == ST_LAUNCH) r_wait_cnt <= '0;
      else if (r_state == ST_WAIT) r_wait_cnt <= w_wait_cnt_inc;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign w_timeout_rd  = '0;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_cur_next    = r_cur;
    w_mask_q_next = r_mask_q;
    w_clr_flags   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start && !w_abort) begin
          w_mask_q_next = r_mask;
          w_clr_flags   = 1'b1;
          if (w_sel_valid) begin
            w_cur_next   = w_sel_idx;
            w_state_next = ST_LAUNCH;
          end else begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_LAUNCH: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (w_done_cur) w_state_next = ST_ACK;
        else if (w_timeout_hit) w_state_next = ST_ERR;
      end
      ST_ACK: begin
        if (w_sel_valid) begin
          w_cur_next   = w_sel_idx;
          w_state_next = ST_LAUNCH;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      ST_ERR:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    // Abort drops straight back to IDLE without touching cur or the IRQ.
    if (w_abort && w_busy) begin
      w_state_next = ST_IDLE;
      w_cur_next   = r_cur;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state  <= ST_IDLE;
      r_mask   <= '0;
      r_mask_q <= '0;
      r_cur    <= '0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cur    <= w_cur_next;
      r_mask_q <= w_mask_q_next;
      if (w_wr_mask) r_mask <= cfg_wdata[NUM_LAYERS-1:0];
      if (w_clr_flags) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end else begin
        if (r_state == ST_DONE) r_done  <= 1'b1;
        if (r_state == ST_ERR)  r_error <= 1'b1;
      end
      // Completion outranks a simultaneous IRQ_CLR.
      if ((r_state == ST_DONE) || (r_state == ST_ERR)) r_irq <= 1'b1;
      else if (w_irq_clr) r_irq <= 1'b0;
    end
  end

  assign layer_start = (r_state == ST_LAUNCH) ? w_cur_oh : '0;
  assign layer_ack   = (r_state == ST_ACK)    ? w_cur_oh : '0;
  assign sched_irq   = r_irq;
  assign cfg_wready  = 1'b1;

  always_comb begin
    cfg_rdata = '0;
    case (cfg_raddr)
      REG_MASK:    cfg_rdata = 32'(r_mask);
      REG_STATUS: begin
        cfg_rdata[STAT_BUSY]            = w_busy;
        cfg_rdata[STAT_DONE]            = r_done;
        cfg_rdata[STAT_ERROR]           = r_error;
        cfg_rdata[STAT_CUR_LSB +: 3]    = r_cur;
      end
      REG_TIMEOUT: cfg_rdata = w_timeout_rd;
      default:     cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Scoreboard bench for cnn_layer_sched: stimulus queues expected pulses/IRQ edges with
// their cycle numbers; a negedge monitor pops and compares each observed output event.
module tb_cnn_layer_sched;

  localparam int NL      = 4;
  localparam int K_START = 0;
  localparam int K_ACK   = 1;
  localparam int K_IRQ   = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cfg_wvalid;
  logic [3:0]    cfg_waddr;
  logic [31:0]   cfg_wdata;
  logic          cfg_wready;
  logic [3:0]    cfg_raddr;
  logic [31:0]   cfg_rdata;
  logic [NL-1:0] layer_start;
  logic [NL-1:0] layer_done = '0;
  logic [NL-1:0] layer_ack;
  logic          sched_irq;

  cnn_layer_sched #(.NUM_LAYERS(NL)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_wvalid  (cfg_wvalid),
    .cfg_waddr   (cfg_waddr),
    .cfg_wdata   (cfg_wdata),
    .cfg_wready  (cfg_wready),
    .cfg_raddr   (cfg_raddr),
    .cfg_rdata   (cfg_rdata),
    .layer_start (layer_start),
    .layer_done  (layer_done),
    .layer_ack   (layer_ack),
    .sched_irq   (sched_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;
    logic [NL-1:0] vec;
    int            cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic push(input int k, input logic [NL-1:0] v, input int c);
    ev_t e;
    e.kind = k; e.vec = v; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input logic [NL-1:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d vec=%b cyc=%0d, required no event", k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.vec != v || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind=%0d vec=%b cyc=%0d, required kind=%0d vec=%b cyc=%0d",
                 k, v, cyc, e.kind, e.vec, e.cyc);
      end else begin
        $display("ok event kind=%0d vec=%b cyc=%0d", k, v, cyc);
      end
    end
  endtask

  // Monitor: every start/ack pulse and every IRQ rising edge is one transaction.
  logic irq_prev = 1'b0;
  always @(negedge clk) begin
    if (layer_start != '0) observe(K_START, layer_start);
    if (layer_ack != '0) observe(K_ACK, layer_ack);
    if (sched_irq && !irq_prev) observe(K_IRQ, '0);
    irq_prev = sched_irq;
  end

  // Layer model: with resp_en, raise done 3 cycles after a start and drop it on ack.
  logic          resp_en = 1'b0;
  logic [NL-1:0] manual_done = '0;
  int            pend_idx = 0;
  int            pend_cnt = 0;
  always @(negedge clk) begin
    if (!resp_en) begin
      layer_done = manual_done;
      pend_cnt   = 0;
    end else begin
      if (layer_ack != '0) layer_done = layer_done & ~layer_ack;
      if (layer_start != '0) begin
        for (int i = 0; i < NL; i++) if (layer_start[i]) pend_idx = i;
        pend_cnt = 3;
      end else if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) layer_done[pend_idx] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("ok %s: %h", name, act);
    end
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    cfg_raddr = a;
    #1;
    chk(name, cfg_rdata, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, output int edge_cyc);
    @(posedge clk); #1;
    cfg_wvalid = 1'b1; cfg_waddr = a; cfg_wdata = d;
    @(posedge clk); #1;
    edge_cyc   = cyc;
    cfg_wvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending events after %0d cycles, required 0", name, exp_q.size(), max);
      exp_q.delete();
    end else begin
      $display("ok %s: all events seen", name);
    end
  endtask

  task automatic push_full_1011(input int w);
    push(K_START, 4'b0001, w);
    push(K_ACK,   4'b0001, w + 4);
    push(K_START, 4'b0010, w + 5);
    push(K_ACK,   4'b0010, w + 9);
    push(K_START, 4'b1000, w + 10);
    push(K_ACK,   4'b1000, w + 14);
    push(K_IRQ,   4'b0000, w + 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int c;
    resetn = 1'b1; cfg_wvalid = 1'b0; cfg_waddr = '0; cfg_wdata = '0; cfg_raddr = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_wready", 32'(cfg_wready), 32'd1);
    chk("rst_irq", 32'(sched_irq), 32'd0);
    chk("rst_start", 32'(layer_start), 32'd0);
    chk("rst_ack", 32'(layer_ack), 32'd0);
    rd_chk("rst_status", 4'h8, 32'h0);
    rd_chk("rst_mask", 4'h4, 32'h0);
    rd_chk("rst_timeout", 4'hC, 32'h0);
    rd_chk("unmapped_rd", 4'h1, 32'h0);

    // Full run over layers 0,1,3
    wr(4'h4, 32'hB, w);
    rd_chk("mask_rd", 4'h4, 32'hB);
    resp_en = 1'b1;
    wr(4'h0, 32'h1, w);
    push_full_1011(w);
    rd_chk("status_busy", 4'h8, 32'h001);
    wait_drain("run_1011", 40);
    rd_chk("status_1011", 4'h8, 32'h302);
    chk("irq_1011", 32'(sched_irq), 32'd1);
    wr(4'h0, 32'h4, w);
    chk("irq_clr", 32'(sched_irq), 32'd0);

    // Empty mask goes straight to DONE
    wr(4'h4, 32'h0, w);
    wr(4'h0, 32'h1, w);
    push(K_IRQ, 4'b0000, w + 1);
    wait_drain("empty_mask", 10);
    cfg_raddr = 4'h8; #1;
    chk("status_done_empty", cfg_rdata & 32'h7, 32'h2);
    wr(4'h0, 32'h4, w);

    // Foreign done bits ignored while waiting on layer 1
    resp_en = 1'b0; manual_done = '0;
    wr(4'h4, 32'h2, w);
    wr(4'h0, 32'h1, w);
    push(K_START, 4'b0010, w);
    repeat (2) begin @(posedge clk); #1; end
    manual_done = 4'b0101;
    repeat (3) begin @(posedge clk); #1; end
    c = cyc;
    manual_done = 4'b0111;
    push(K_ACK, 4'b0010, c + 1);
    push(K_IRQ, 4'b0000, c + 3);
    @(posedge clk); #1;
    manual_done = '0;
    wait_drain("done_select", 10);
    wr(4'h0, 32'h4, w);

    // ABORT during WAIT, START+ABORT in idle, then restart
    wr(4'h4, 32'hA, w);
    wr(4'h0, 32'h1, w);
    push(K_START, 4'b0010, w);
    repeat (3) begin @(posedge clk); #1; end
    wr(4'h0, 32'h2, w);
    cfg_raddr = 4'h8; #1;
    chk("abort_busy", cfg_rdata & 32'h1, 32'h0);
    chk("abort_irq", 32'(sched_irq), 32'd0);
    wr(4'h0, 32'h3, w);
    repeat (3) begin @(posedge clk); #1; end
    cfg_raddr = 4'h8; #1;
    chk("start_abort_idle", cfg_rdata & 32'h1, 32'h0);
    resp_en = 1'b1;
    wr(4'h0, 32'h1, w);
    push(K_START, 4'b0010, w);
    push(K_ACK,   4'b0010, w + 4);
    push(K_START, 4'b1000, w + 5);
    push(K_ACK,   4'b1000, w + 9);
    push(K_IRQ,   4'b0000, w + 11);
    wait_drain("restart", 30);
    wr(4'h0, 32'h4, w);

`ifdef CNN_SCHED_TIMEOUT_EN
    resp_en = 1'b0; manual_done = '0;
    wr(4'hC, 32'd10, w);
    rd_chk("timeout_rd", 4'hC, 32'd10);
    wr(4'h4, 32'h4, w);
    wr(4'h0, 32'h1, w);
    push(K_START, 4'b0100, w);
    push(K_IRQ, 4'b0000, w + 12);
    wait_drain("timeout", 30);
    rd_chk("status_err", 4'h8, 32'h204);
    chk("irq_err", 32'(sched_irq), 32'd1);
    wr(4'h0, 32'h4, w);
    chk("irq_err_clr", 32'(sched_irq), 32'd0);
    wr(4'hC, 32'd0, w);
`else
    wr(4'hC, 32'd10, w);
    rd_chk("timeout_ignored", 4'hC, 32'h0);
`endif

    // Reset while waiting: set IRQ first so the reset has something to clear
    wr(4'h4, 32'h0, w);
    wr(4'h0, 32'h1, w);
    push(K_IRQ, 4'b0000, w + 1);
    wait_drain("pre_reset_irq", 10);
    resp_en = 1'b0; manual_done = '0;
    wr(4'h4, 32'h3, w);
    wr(4'h0, 32'h1, w);
    push(K_START, 4'b0001, w);
    repeat (3) begin @(posedge clk); #1; end
    resetn = 1'b1;
    #1;
    chk("mid_rst_start", 32'(layer_start), 32'd0);
    chk("mid_rst_ack", 32'(layer_ack), 32'd0);
    chk("mid_rst_irq", 32'(sched_irq), 32'd0);
    rd_chk("mid_rst_status", 4'h8, 32'h0);
    rd_chk("mid_rst_mask", 4'h4, 32'h0);
    #2 resetn = 1'b0;
    wr(4'h4, 32'hB, w);
    resp_en = 1'b1;
    wr(4'h0, 32'h1, w);
    push_full_1011(w);
    wait_drain("post_reset_run", 40);
    rd_chk("post_reset_status", 4'h8, 32'h302);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
